// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited imem requests, response FIFO to decode.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises a sticky misalign_trap.
module fetch_unit #(
   parameter int                 BIN_DIG  = 32,
   parameter logic [BIN_DIG-1:0] RESET_PC = '0,
   parameter int                 DEPTH    = 2
) (
   input  logic               CLK,
   input  logic               RST,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [BIN_DIG-1:0] imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [BIN_DIG-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [BIN_DIG-1:0] redirect_pc,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [BIN_DIG-1:0] dec_inst,
   output logic [BIN_DIG-1:0] dec_pc,
   output logic               misalign_trap
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

   state_t             state;
   logic [BIN_DIG-1:0] fetch_pc;
   logic [BIN_DIG-1:0] rsp_pc;
   logic [CNT_W-1:0]   outstanding;
   logic [CNT_W-1:0]   drop_cnt;
   logic [CNT_W-1:0]   count;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [BIN_DIG-1:0] fifo_inst [DEPTH];
   logic [BIN_DIG-1:0] fifo_pc   [DEPTH];

   logic               req_fire;
   logic               rsp_fire;
   logic               push;
   logic               pop;
   logic               misaligned;
   logic [CNT_W:0]     in_flight;
   logic [CNT_W-1:0]   out_next;
   logic [CNT_W-1:0]   count_next;
   logic [BIN_DIG-1:0] target;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned    = (redirect_pc[1:0] != 2'b00);
   assign misalign_trap = (state == HALT);
`else
   assign misaligned    = 1'b0;
   assign misalign_trap = 1'b0;
`endif

   // Low address bits are dropped so fetch always stays word aligned.
   assign target    = redirect_pc & ~BIN_DIG'(3);
   assign in_flight = {1'b0, outstanding} + {1'b0, count};

   assign imem_req_valid = (state != HALT) && !redirect_valid && (in_flight < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign rsp_fire       = imem_rsp_valid;

   assign dec_valid = (count != '0) && !redirect_valid && (state != HALT);
   assign dec_inst  = (count != '0) ? fifo_inst[rd_ptr] : '0;
   assign dec_pc    = (count != '0) ? fifo_pc[rd_ptr]   : '0;

   assign push = rsp_fire && (drop_cnt == '0) && !redirect_valid;
   assign pop  = dec_valid && dec_ready;

   always_comb begin
      out_next = outstanding;
      if (req_fire && !rsp_fire)
         out_next = outstanding + 1'b1;
      else if (!req_fire && rsp_fire)
         out_next = outstanding - 1'b1;
   end

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= out_next;
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be discarded.
            fetch_pc <= target;
            rsp_pc   <= target;
            drop_cnt <= out_next;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            if (state == HALT || misaligned)
               state <= HALT;
            else if (out_next != '0)
               state <= DRAIN;
            else
               state <= RUN;
         end else begin
            count <= count_next;
            if (req_fire)
               fetch_pc <= fetch_pc + BIN_DIG'(4);
            if (push) begin
               rsp_pc <= rsp_pc + BIN_DIG'(4);
               wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop)
               rd_ptr <= ptr_inc(rd_ptr);
            if (rsp_fire && drop_cnt != '0) begin
               drop_cnt <= drop_cnt - 1'b1;
               if (state == DRAIN && drop_cnt == CNT_W'(1))
                  state <= RUN;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_inst[wr_ptr] <= imem_rsp_data;
         fifo_pc[wr_ptr]   <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency plus a queue-based reference.
module tb_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_inst;
   logic [31:0] dec_pc;
   logic        misalign_trap;

   always #5 CLK = ~CLK;

   fetch_unit #(.BIN_DIG(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .misalign_trap(misalign_trap)
   );

   typedef struct packed { logic [31:0] addr; int due; } pend_t;
   typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;

   int errors = 0;
   int checks = 0;

   pend_t pend[$];
   int    now = 0;
   int    last_due = 0;
   int    lat_min = 1;
   int    lat_max = 1;

   ent_t        mq[$];
   logic [31:0] m_fetch, m_rsp;
   int          m_out, m_drop;
   bit          m_halt;

   logic        obs_req, obs_dv;
   logic [31:0] obs_addr, obs_pc;
   logic [31:0] last_pop_pc = 32'h0;
   int          pops = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic bit is_misaligned(input logic [31:0] p);
      return (p[1:0] != 2'b00) && MIS_EN;
   endfunction

   task automatic model_reset();
      mq.delete();
      pend.delete();
      m_fetch  = RESET_PC;
      m_rsp    = RESET_PC;
      m_out    = 0;
      m_drop   = 0;
      m_halt   = 1'b0;
      last_due = now;
   endtask

   // One clock cycle: act as memory, drive inputs, compare against the reference, advance the reference.
   task automatic cycle(input bit rdr, input logic [31:0] rpc, input bit drdy, input bit rdy);
      bit          rsp_v, exp_req, exp_dv, req_fire;
      logic [31:0] rsp_addr;
      int          due;
      rsp_v    = (pend.size() > 0) && (pend[0].due <= now);
      rsp_addr = rsp_v ? pend[0].addr : 32'h0;
      imem_rsp_valid = rsp_v;
      imem_rsp_data  = rsp_v ? inst_of(rsp_addr) : $urandom();
      imem_req_ready = rdy;
      redirect_valid = rdr;
      redirect_pc    = rpc;
      dec_ready      = drdy;
      #1;
      exp_req = !m_halt && !rdr && ((m_out + mq.size()) < DEPTH);
      exp_dv  = !m_halt && !rdr && (mq.size() > 0);
      obs_req = imem_req_valid; obs_addr = imem_req_addr;
      obs_dv  = dec_valid;      obs_pc   = dec_pc;
      if (dec_valid === 1'b1 && drdy) begin last_pop_pc = dec_pc; pops++; end
      checks++;
      if (imem_req_valid !== exp_req) begin
         errors++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", now, imem_req_valid, exp_req);
      end
      if (exp_req) begin
         checks++;
         if (imem_req_addr !== m_fetch) begin
            errors++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", now, imem_req_addr, m_fetch);
         end
      end
      checks++;
      if (dec_valid !== exp_dv) begin
         errors++; $display("FAIL dec_valid cyc=%0d got=%b exp=%b", now, dec_valid, exp_dv);
      end
      if (exp_dv) begin
         checks++;
         if (dec_pc !== mq[0].pc || dec_inst !== mq[0].inst) begin
            errors++;
            $display("FAIL dec_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                     now, dec_pc, dec_inst, mq[0].pc, mq[0].inst);
         end
      end
      checks++;
      if (misalign_trap !== m_halt) begin
         errors++; $display("FAIL trap cyc=%0d got=%b exp=%b", now, misalign_trap, m_halt);
      end
      req_fire = exp_req && rdy;
      if (req_fire) begin
         due = now + $urandom_range(lat_max, lat_min);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend.push_back('{addr: m_fetch, due: due});
      end
      if (rsp_v) pend.delete(0);
      m_out = m_out + int'(req_fire) - int'(rsp_v);
      if (rdr) begin
         mq.delete();
         m_drop  = m_out;
         m_fetch = rpc & ~32'h3;
         m_rsp   = rpc & ~32'h3;
         if (is_misaligned(rpc)) m_halt = 1'b1;
      end else begin
         if (exp_dv && drdy) mq.delete(0);
         if (rsp_v) begin
            if (m_drop > 0) m_drop--;
            else begin
               mq.push_back('{pc: m_rsp, inst: inst_of(rsp_addr)});
               m_rsp = m_rsp + 32'd4;
            end
         end
         if (req_fire) m_fetch = m_fetch + 32'd4;
      end
      @(negedge CLK);
      now++;
   endtask

   task automatic test_reset();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
      RST = 1'b0;
      #1;
      checks++;
      if (imem_req_addr !== RESET_PC || dec_valid !== 1'b0 || dec_inst !== 32'h0 ||
          dec_pc !== 32'h0 || misalign_trap !== 1'b0) begin
         errors++;
         $display("FAIL reset_values got addr=%h dv=%b inst=%h pc=%h trap=%b exp addr=%h others 0",
                  imem_req_addr, dec_valid, dec_inst, dec_pc, misalign_trap, RESET_PC);
      end
      repeat (2) @(negedge CLK);
      now += 2;
      RST = 1'b1;
      model_reset();
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("FAIL reset_release got valid=%b addr=%h exp valid=1 addr=%h",
                  imem_req_valid, imem_req_addr, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] addrs[$];
      logic [31:0] pcs[$];
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 30; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         if (obs_req) addrs.push_back(obs_addr);
         if (obs_dv) pcs.push_back(obs_pc);
      end
      checks++;
      if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8) begin
         errors++; $display("FAIL seq_addrs got n=%0d first=%h exp 0,4,8", addrs.size(),
                            (addrs.size() > 0) ? addrs[0] : 32'hx);
      end
      checks++;
      if (pcs.size() < 15 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4) begin
         errors++; $display("FAIL seq_dec got n=%0d exp >=15 starting 0,4", pcs.size());
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] prev;
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
      prev = last_pop_pc;
      checks++;
      if (imem_req_valid !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== prev + 32'd4) begin
         errors++; $display("FAIL bp_full got req=%b dv=%b pc=%h exp req=0 dv=1 pc=%h",
                            imem_req_valid, dec_valid, dec_pc, prev + 32'd4);
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      checks++;
      if (last_pop_pc !== prev + 32'd4) begin
         errors++; $display("FAIL bp_release got pc=%h exp=%h", last_pop_pc, prev + 32'd4);
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
   endtask

   task automatic test_redirect();
      int  n;
      bit  seen;
      lat_min = 3; lat_max = 3;
      n = 0;
      while (m_out != 2 && n < 20) begin cycle(1'b0, 32'h0, 1'b1, 1'b1); n++; end
      checks++;
      if (m_out != 2) begin errors++; $display("FAIL redir_setup got outstanding=%0d exp=2", m_out); end
      cycle(1'b1, 32'h100, 1'b1, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         if (obs_dv) seen = 1'b1;
      end
      checks++;
      if (!seen || obs_pc !== 32'h100) begin
         errors++; $display("FAIL redir_first got seen=%b pc=%h exp pc=00000100", seen, obs_pc);
      end
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_redirect_collide();
      int n;
      bit seen;
      n = 0;
      while (!((pend.size() > 0) && (pend[0].due <= now) && (mq.size() > 0)) && n < 20) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1); n++;
      end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL collide_setup got timeout exp rsp+dec cycle"); end
      cycle(1'b1, 32'h200, 1'b1, 1'b1);
      checks++;
      if (obs_dv !== 1'b0) begin errors++; $display("FAIL collide_dv got=%b exp=0", obs_dv); end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         if (obs_dv) seen = 1'b1;
      end
      checks++;
      if (!seen || obs_pc !== 32'h200) begin
         errors++; $display("FAIL collide_first got seen=%b pc=%h exp pc=00000200", seen, obs_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] addrs[$];
      logic [31:0] pcs[$];
      cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         if (obs_req) addrs.push_back(obs_addr);
         if (obs_dv) pcs.push_back(obs_pc);
      end
      checks++;
      if (addrs.size() < 3 || addrs[1] !== 32'hFFFF_FFFC || addrs[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_addr got n=%0d exp ..FFFC then 00000000", addrs.size());
      end
      checks++;
      if (pcs.size() < 3 || pcs[0] !== 32'hFFFF_FFF8 || pcs[2] !== 32'h0) begin
         errors++; $display("FAIL wrap_dec got n=%0d exp FFFFFFF8,FFFFFFFC,00000000", pcs.size());
      end
   endtask

   task automatic test_random();
      int          start;
      logic [31:0] rpc;
      bit          rdr;
      start = pops;
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         rdr = ($urandom_range(0, 19) == 0);
         rpc = $urandom();
         if (MIS_EN) rpc[1:0] = 2'b00;
         cycle(rdr, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
      checks++;
      if (pops - start < 20) begin
         errors++; $display("FAIL random_progress got=%0d exp>=20", pops - start);
      end
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_misalign();
      bit seen;
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
      cycle(1'b1, 32'h102, 1'b1, 1'b1);
      if (MIS_EN) begin
         seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_req || obs_dv) seen = 1'b1;
         end
         checks++;
         if (seen || misalign_trap !== 1'b1) begin
            errors++; $display("FAIL halt got activity=%b trap=%b exp activity=0 trap=1", seen, misalign_trap);
         end
         test_reset();
         cycle(1'b0, 32'h0, 1'b1, 1'b1);
         checks++;
         if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            errors++; $display("FAIL halt_exit got req=%b addr=%h exp req=1 addr=%h", obs_req, obs_addr, RESET_PC);
         end
      end else begin
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b1);
            if (obs_dv) seen = 1'b1;
         end
         checks++;
         if (!seen || obs_pc !== 32'h100) begin
            errors++; $display("FAIL misalign_ignored got seen=%b pc=%h exp pc=00000100", seen, obs_pc);
         end
      end
   endtask

   initial begin
      RST = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
      @(negedge CLK);
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_redirect_collide();
      test_wrap();
      test_random();
      test_reset();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
